// File: rtl/mac_resolve_pkg.sv
// Shared constants and FSM encoding for the MAC carry-save resolver.
package mac_resolve_pkg;

    localparam int MR_W        = 40;
    localparam int OVF_MSB_DEF = 31;

    localparam logic [MR_W-1:0] SAT_POS = 40'h007FFFFFFF;
    localparam logic [MR_W-1:0] SAT_NEG = 40'hFF80000000;

    typedef enum logic {
        IDLE   = 1'b0,
        ADD_HI = 1'b1
    } state_t;

endpackage

// File: rtl/mac_cpa_slice.sv
// Parameterised-width carry-propagate adder slice with carry-in and carry-out.
module mac_cpa_slice #(
    parameter int W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/mac_resolve.sv
// MAC back end: two-stage carry-propagate resolve of the array's carry-save result,
// overflow detection, MR accumulator and feedback. Saturation is built only with MAC_SAT_EN.
module mac_resolve
    import mac_resolve_pkg::*;
#(
    parameter int LO_W    = 20,
    parameter int OVF_MSB = OVF_MSB_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            VLD_E,
    output logic            RDY_E,
    input  logic [36:0]     SUM_E,
    input  logic [36:0]     CRY_E,
    input  logic [2:0]      MLSB_E,
    input  logic            ACC_E,
    input  logic            SAT_E,
    input  logic            MV_CLR,
    output logic [MR_W-1:0] MR_C,
    output logic [15:0]     MRa_E,
    output logic [25:0]     MRb_E,
    output logic            DONE_C,
    output logic            MV_C
);

    localparam int HI_W = MR_W - LO_W;

    state_t state, state_nxt;
    logic   xfer, load;

    logic [MR_W-1:0] op_a, op_b;
    logic [LO_W-1:0] lo_sum, lo_q;
    logic            lo_co, c_lo_q;
    logic [HI_W-1:0] hi_a_q, hi_b_q, hi_sum;
    logic            hi_co_unused;
    logic            acc_q;
    logic [MR_W-1:0] r, mr_new;
    logic [MR_W-1:OVF_MSB] guard;
    logic            ovf;

    assign op_a = {SUM_E, MLSB_E};
    assign op_b = {CRY_E, 3'b000};
    assign xfer = VLD_E & RDY_E;

    // ---- FSM ----
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = ADD_HI;
            ADD_HI:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        RDY_E = 1'b0;
        load  = 1'b0;
        case (state)
            IDLE:    RDY_E = 1'b1;
            ADD_HI:  load  = 1'b1;
            default: RDY_E = 1'b0;
        endcase
    end

    // ---- Stage 1: low slice resolved on the transfer edge ----
    mac_cpa_slice #(.W(LO_W)) u_lo (
        .a  (op_a[LO_W-1:0]),
        .b  (op_b[LO_W-1:0]),
        .ci (1'b0),
        .s  (lo_sum),
        .co (lo_co)
    );

`ifdef MAC_SAT_EN
    logic sat_q;
`else
    logic sat_unused;
    assign sat_unused = SAT_E;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            lo_q   <= '0;
            c_lo_q <= 1'b0;
            hi_a_q <= '0;
            hi_b_q <= '0;
            acc_q  <= 1'b0;
`ifdef MAC_SAT_EN
            sat_q  <= 1'b0;
`endif
        end else if (xfer) begin
            lo_q   <= lo_sum;
            c_lo_q <= lo_co;
            hi_a_q <= op_a[MR_W-1:LO_W];
            hi_b_q <= op_b[MR_W-1:LO_W];
            acc_q  <= ACC_E;
`ifdef MAC_SAT_EN
            sat_q  <= SAT_E;
`endif
        end
    end

    // ---- Stage 2: high slice, carry out of bit 39 dropped ----
    mac_cpa_slice #(.W(HI_W)) u_hi (
        .a  (hi_a_q),
        .b  (hi_b_q),
        .ci (c_lo_q),
        .s  (hi_sum),
        .co (hi_co_unused)
    );

    assign r     = {hi_sum, lo_q};
    assign guard = r[MR_W-1:OVF_MSB];
    assign ovf   = ~(&guard | ~|guard);

    always_comb begin
        mr_new = r;
`ifdef MAC_SAT_EN
        if (sat_q && ovf) mr_new = r[MR_W-1] ? SAT_NEG : SAT_POS;
`endif
    end

    // MR and both feedback operands move on the same edge so the array never sees a mix.
    always_ff @(posedge CLK) begin
        if (RST) begin
            MR_C   <= '0;
            MRa_E  <= '0;
            MRb_E  <= '0;
            DONE_C <= 1'b0;
            MV_C   <= 1'b0;
        end else begin
            DONE_C <= load;
            if (load) begin
                MR_C  <= mr_new;
                MRa_E <= acc_q ? mr_new[15:0] : 16'h0;
                MRb_E <= acc_q ? {mr_new[MR_W-1:16], 2'b00} : 26'h0;
            end
            if (load && ovf)  MV_C <= 1'b1;
            else if (MV_CLR)  MV_C <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_resolve.sv
// Self-checking bench for mac_resolve: constant vector table, corner sequences, random ops vs model.
module tb_mac_resolve;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        VLD_E = 1'b0, ACC_E = 1'b0, SAT_E = 1'b0, MV_CLR = 1'b0;
    logic [36:0] SUM_E = '0, CRY_E = '0;
    logic [2:0]  MLSB_E = '0;
    logic        RDY_E, DONE_C, MV_C;
    logic [39:0] MR_C;
    logic [15:0] MRa_E;
    logic [25:0] MRb_E;

    mac_resolve dut (
        .CLK(CLK), .RST(RST), .VLD_E(VLD_E), .RDY_E(RDY_E),
        .SUM_E(SUM_E), .CRY_E(CRY_E), .MLSB_E(MLSB_E),
        .ACC_E(ACC_E), .SAT_E(SAT_E), .MV_CLR(MV_CLR),
        .MR_C(MR_C), .MRa_E(MRa_E), .MRb_E(MRb_E),
        .DONE_C(DONE_C), .MV_C(MV_C)
    );

    always #5 CLK = ~CLK;

    int   total = 0;
    int   bad   = 0;
    logic mv_m  = 1'b0;

    typedef struct {
        logic [36:0] sum;
        logic [36:0] cry;
        logic [2:0]  mlsb;
        logic        acc;
        logic        sat;
        logic [39:0] exp_mr;
        logic [15:0] exp_a;
        logic [25:0] exp_b;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain 40-bit modular addition and a signed range test on the result.
    function automatic logic [39:0] model_r(input logic [36:0] s, input logic [36:0] c, input logic [2:0] m);
        logic [39:0] a, b;
        a = {s, m};
        b = {c, 3'b000};
        return a + b;
    endfunction

    function automatic logic model_ovf(input logic [39:0] r);
        longint v;
        v = longint'($signed(r));
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    function automatic logic [39:0] model_mr(input logic [39:0] r, input logic sat);
`ifdef MAC_SAT_EN
        if (sat && model_ovf(r)) return r[39] ? 40'hFF80000000 : 40'h007FFFFFFF;
`else
        if (sat) return r;
`endif
        return r;
    endfunction

    task automatic do_op(input logic [36:0] s, input logic [36:0] c, input logic [2:0] m,
                         input logic a, input logic sa, input logic clr, output logic [39:0] mr_o);
        logic [39:0] r, mr;
        logic [63:0] eb;
        logic        ov;
        @(negedge CLK);
        chk("rdy_idle", 64'(RDY_E), 64'd1);
        chk("done_idle", 64'(DONE_C), 64'd0);
        VLD_E = 1'b1; SUM_E = s; CRY_E = c; MLSB_E = m; ACC_E = a; SAT_E = sa; MV_CLR = clr;
        @(negedge CLK);
        VLD_E = 1'b0; SUM_E = ~s; CRY_E = ~c; MLSB_E = ~m; ACC_E = ~a; SAT_E = ~sa;
        chk("rdy_busy", 64'(RDY_E), 64'd0);
        chk("done_early", 64'(DONE_C), 64'd0);
        @(negedge CLK);
        MV_CLR = 1'b0;
        r  = model_r(s, c, m);
        ov = model_ovf(r);
        mr = model_mr(r, sa);
        mv_m = ov | (mv_m & ~clr);
        eb = a ? ((64'(mr) >> 16) << 2) : 64'd0;
        chk("done", 64'(DONE_C), 64'd1);
        chk("mr", 64'(MR_C), 64'(mr));
        chk("mra", 64'(MRa_E), a ? 64'(mr % 40'd65536) : 64'd0);
        chk("mrb", 64'(MRb_E), eb);
        chk("fb_sum", 64'(MRa_E) + (64'(MRb_E) << 14), a ? 64'(mr) : 64'd0);
        chk("mv", 64'(MV_C), 64'(mv_m));
        mr_o = MR_C;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [39:0] mr_o, ra, rb;
        logic [36:0] s, c;
        logic signed [27:0] t1;
        logic signed [26:0] t2;
        int dones;

        tbl[0] = '{37'h5,         37'h3, 3'b101, 1'b0, 1'b0, 40'h45,         16'h0,    26'h0};
        tbl[1] = '{37'h2468ACF,   37'h0, 3'b000, 1'b1, 1'b0, 40'h0012345678, 16'h5678, 26'h48D0};
        tbl[2] = '{37'h1FFFF,     37'h1, 3'b000, 1'b1, 1'b0, 40'h0000100000, 16'h0,    26'h40};
`ifdef MAC_SAT_EN
        tbl[3] = '{37'h10000000,  37'h0, 3'b000, 1'b1, 1'b1, 40'h007FFFFFFF, 16'hFFFF, 26'h1FFFC};
        tbl[4] = '{37'h1FE0000000,37'h0, 3'b000, 1'b0, 1'b1, 40'hFF80000000, 16'h0,    26'h0};
`else
        tbl[3] = '{37'h10000000,  37'h0, 3'b000, 1'b1, 1'b1, 40'h0080000000, 16'h0,    26'h20000};
        tbl[4] = '{37'h1FE0000000,37'h0, 3'b000, 1'b0, 1'b1, 40'hFF00000000, 16'h0,    26'h0};
`endif
        tbl[5] = '{37'h1FFFFFFFFF,37'h0, 3'b111, 1'b1, 1'b0, 40'hFFFFFFFFFF, 16'hFFFF, 26'h3FFFFFC};
        tbl[6] = '{37'h1FFFFFFFFF,37'h1, 3'b000, 1'b1, 1'b1, 40'h0,          16'h0,    26'h0};
        tbl[7] = '{37'hFFFFFFF,   37'h0, 3'b000, 1'b0, 1'b1, 40'h007FFFFFF8, 16'h0,    26'h0};
        tbl[8] = '{37'h1FF0000000,37'h0, 3'b000, 1'b0, 1'b1, 40'hFF80000000, 16'h0,    26'h0};

        // Reset state
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_mr", 64'(MR_C), 64'd0);
        chk("rst_rdy", 64'(RDY_E), 64'd1);
        chk("rst_done", 64'(DONE_C), 64'd0);
        chk("rst_mv", 64'(MV_C), 64'd0);
        chk("rst_fb", 64'(MRa_E) | 64'(MRb_E), 64'd0);
        RST = 1'b0;

        // Constant vectors
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].sum, tbl[i].cry, tbl[i].mlsb, tbl[i].acc, tbl[i].sat, 1'b0, mr_o);
            chk($sformatf("tbl%0d_mr", i), 64'(MR_C), 64'(tbl[i].exp_mr));
            chk($sformatf("tbl%0d_mra", i), 64'(MRa_E), 64'(tbl[i].exp_a));
            chk($sformatf("tbl%0d_mrb", i), 64'(MRb_E), 64'(tbl[i].exp_b));
        end

        // Sticky overflow: clear, then coincident set and clear
        @(negedge CLK);
        MV_CLR = 1'b1;
        @(negedge CLK);
        MV_CLR = 1'b0;
        mv_m = 1'b0;
        chk("mv_clr", 64'(MV_C), 64'd0);
        do_op(37'h10000000, 37'h0, 3'b000, 1'b0, 1'b0, 1'b1, mr_o);
        chk("mv_set_wins", 64'(MV_C), 64'd1);
        do_op(37'h10, 37'h0, 3'b000, 1'b0, 1'b0, 1'b0, mr_o);
        chk("mv_sticky", 64'(MV_C), 64'd1);

        // Back-to-back: VLD_E held for four cycles
        ra = model_r(37'h100, 37'h0, 3'b001);
        rb = model_r(37'h200, 37'h0, 3'b010);
        dones = 0;
        @(negedge CLK);
        VLD_E = 1'b1; SUM_E = 37'h100; CRY_E = '0; MLSB_E = 3'b001; ACC_E = 1'b0; SAT_E = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_rdy%0d", i), 64'(RDY_E), (i % 2 == 0) ? 64'd1 : 64'd0);
            if (DONE_C) dones++;
            if (i == 2) chk("b2b_mr_a", 64'(MR_C), 64'(ra));
            @(negedge CLK);
            if (i == 0) begin SUM_E = 37'h200; MLSB_E = 3'b010; end
        end
        VLD_E = 1'b0;
        if (DONE_C) dones++;
        chk("b2b_mr_b", 64'(MR_C), 64'(rb));
        @(negedge CLK);
        if (DONE_C) dones++;
        chk("b2b_dones", 64'(dones), 64'd2);

        // Random ops against the reference model
        for (int n = 0; n < 40; n++) begin
            s = 37'({$urandom(), $urandom()});
            c = 37'({$urandom(), $urandom()});
            if ($urandom_range(1) == 1) begin
                t1 = 28'($urandom());
                t2 = 27'($urandom());
                s = {{9{t1[27]}}, t1};
                c = {{10{t2[26]}}, t2};
            end
            do_op(s, c, 3'($urandom()), 1'($urandom()), 1'($urandom()),
                  ($urandom_range(3) == 0), mr_o);
        end

        // Reset while the high stage is pending aborts the op
        @(negedge CLK);
        VLD_E = 1'b1; SUM_E = 37'h1234; CRY_E = 37'h1; MLSB_E = 3'b011; ACC_E = 1'b1; SAT_E = 1'b0;
        @(negedge CLK);
        VLD_E = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        mv_m = 1'b0;
        chk("abort_done", 64'(DONE_C), 64'd0);
        chk("abort_mr", 64'(MR_C), 64'd0);
        chk("abort_rdy", 64'(RDY_E), 64'd1);
        chk("abort_mv", 64'(MV_C), 64'd0);
        @(negedge CLK);
        chk("abort_done2", 64'(DONE_C), 64'd0);
        chk("abort_mr2", 64'(MR_C), 64'd0);
        chk("abort_fb", 64'(MRa_E) | 64'(MRb_E), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
